// File: rtl/pulse_count_if.sv
// Register-block side of the pulse counter: strobes and clear in, count and
// overflow strobe out. The external pulse line rides along for convenience.
interface pulse_count_if;
    logic       pulse_en;
    logic       count_clr;
    logic       ext_pulse;
    logic [2:0] count;
    logic       overflow;

    modport master (
        output pulse_en,
        output count_clr,
        output ext_pulse,
        input  count,
        input  overflow
    );

    modport slave (
        input  pulse_en,
        input  count_clr,
        input  ext_pulse,
        output count,
        output overflow
    );
endinterface

// File: rtl/pulse_count_core.sv
// Pulse counter datapath: synchronizes and glitch-filters ext_pulse, adds
// rising events and software strobes into a 3-bit wrapping count.
//
// state  | meaning
// LOW    | line accepted low, waiting for a high sample
// RISE_Q | qualifying a rise, qcnt = consecutive high samples seen
// HIGH   | line accepted high, waiting for a low sample
// FALL_Q | qualifying a fall, qcnt = consecutive low samples seen
module pulse_count_core #(
    parameter int FILTER_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pulse_count_if.slave bus
);
    typedef enum logic [1:0] {LOW, RISE_Q, HIGH, FALL_Q} filt_state_e;

    localparam logic [7:0] QMAX   = 8'(FILTER_LEN - 1);
    localparam bit         SINGLE = (FILTER_LEN == 1);

    logic        s1_q, s2_q;
    filt_state_e state_q, state_d;
    logic [7:0]  qcnt_q, qcnt_d;
    logic        ext_evt;
    logic [1:0]  inc;
    logic [3:0]  sum;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;

    // rst_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= LOW;
            qcnt_q  <= '0;
        end else begin
            s1_q    <= bus.ext_pulse;
            s2_q    <= s1_q;
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        case (state_q)
            LOW: begin
                if (s2_q) begin
                    if (SINGLE) begin
                        state_d = HIGH;
                    end else begin
                        state_d = RISE_Q;
                        qcnt_d  = 8'd1;
                    end
                end
            end
            RISE_Q: begin
                if (!s2_q) begin
                    state_d = LOW;
                    qcnt_d  = '0;
                end else if (qcnt_q == QMAX) begin
                    state_d = HIGH;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d = qcnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (!s2_q) begin
                    if (SINGLE) begin
                        state_d = LOW;
                    end else begin
                        state_d = FALL_Q;
                        qcnt_d  = 8'd1;
                    end
                end
            end
            FALL_Q: begin
                if (s2_q) begin
                    state_d = HIGH;
                    qcnt_d  = '0;
                end else if (qcnt_q == QMAX) begin
                    state_d = LOW;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d = qcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = LOW;
                qcnt_d  = '0;
            end
        endcase
    end

    // Only qualified rises count; falls just re-arm the filter.
    always_comb begin
        ext_evt = 1'b0;
        if (s2_q) begin
            if (state_q == LOW && SINGLE) begin
                ext_evt = 1'b1;
            end else if (state_q == RISE_Q && qcnt_q == QMAX) begin
                ext_evt = 1'b1;
            end
        end
    end

    assign inc = {1'b0, bus.pulse_en} + {1'b0, ext_evt};
    assign sum = {1'b0, count_q} + {2'b00, inc};

    always_comb begin
        if (bus.count_clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            count_d = sum[2:0];
            ovf_d   = sum[3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule

// File: doc/pulse_count_core.md
# pulse_count_core

Counting datapath behind the pulse-counter register block. It takes the software pulse strobe (`pulse_en`) and the clear level (`count_clr`) from the register block. It also takes an external pulse input, which it synchronizes and glitch-filters. It keeps a 3-bit wrapping event count and returns `count[2:0]` and a one-cycle `overflow` strobe to the register block, which makes the overflow flag sticky.

## Interface
- `FILTER_LEN`, default 4: number of consecutive synchronized samples at the new level required before an `ext_pulse` transition is accepted. Legal range is 1..255.
- `clk`  input  1  single clock; all state is updated on its rising edge.
- `rst_n`  input  1  reset, synchronous and active-high: the block is reset on any rising `clk` edge where `rst_n` = 1.
- `pulse_en`  input  1  one-cycle software count strobe from the register block.
- `count_clr`  input  1  clear level from the register block; while it is 1, the count is held at 0.
- `ext_pulse`  input  1  asynchronous external pulse line.
- `count`  output  3  current event count, modulo 8.
- `overflow`  output  1  one-cycle strobe: the count wrapped past 7 on the preceding edge.

## Operation
- **Synchronizer:** a 2-flop chain `s1` → `s2` on `ext_pulse`. Only `s2` is used downstream.
- **Filter FSM states:** `LOW`, `RISE_Q`, `HIGH`, `FALL_Q`. A qualification counter `qcnt` is 8 bits wide.
  - In `LOW`: if `s2` = 1 and `FILTER_LEN` = 1, go to `HIGH` and emit an event. Else if `s2` = 1, go to `RISE_Q` with `qcnt` = 1. Otherwise stay.
  - In `RISE_Q`: if `s2` = 0, go to `LOW` with `qcnt` = 0. Else if `qcnt` = `FILTER_LEN`-1, go to `HIGH`, emit an event, and set `qcnt` = 0. Else increment `qcnt`.
  - `HIGH` and `FALL_Q` mirror `LOW` and `RISE_Q` for `s2` = 0, ending in `LOW`. Falling transitions never emit an event.
- **Event:** the internal `ext_evt` is 1 in the cycle the FSM takes the `RISE_Q`→`HIGH` (or `LOW`→`HIGH`) transition.
- **Count arithmetic:**
  - `inc` = `pulse_en` + `ext_evt`, giving 0, 1 or 2.
  - `sum[3:0]` = {0, `count`} + `inc`.
  - On the next edge, `count` ← `sum[2:0]` and `overflow` ← `sum[3]`.
- **Clear priority:** while `count_clr` = 1, the next `count` is 0 and the next `overflow` is 0. Any `pulse_en` or `ext_evt` in that cycle is discarded. The filter FSM keeps running so filter state is not lost.
- **Reset values:** `count` = 0, `overflow` = 0, `s1` = `s2` = 0, FSM = `LOW`, `qcnt` = 0.
- **Reset priority:** reset overrides clear and all events.
- **Reset mid-qualification:** any partial qualification is abandoned. A line still high after reset must requalify from `LOW` and then produces one event.

## Timing
- **`pulse_en` latency:** `pulse_en` sampled at edge N → `count` updated after edge N. It is visible in cycle N+1.
- **`ext_pulse` latency:** `ext_pulse` first sampled high at edge E0 and held → `count` updated at edge E0+`FILTER_LEN`+1.
  - With `FILTER_LEN` = 4, the update is at E0+5.
- **Pulse rejection:** an `ext_pulse` high shorter than `FILTER_LEN` `s2` samples produces no event.
- **Retrigger spacing:** a new rising event requires a qualified fall first, so the minimum spacing between external events is 2·`FILTER_LEN` cycles.
- **`overflow` timing:**
  - High for exactly one cycle, coincident with the first cycle the wrapped `count` is visible.
  - Never asserted two cycles in a row unless two wraps actually occur.
- **Simultaneous events:** `pulse_en` and `ext_evt` in the same cycle add 2.
  - 6 → 0 with `overflow`.
  - 7 → 1 with `overflow`.
- **Clear timing:** `count_clr` asserted in cycle N → `count` = 0 from cycle N+1 and stays 0 while it is held. Counting resumes from the first cycle with `count_clr` = 0.
- **Outputs:** `count` and `overflow` are registered. There is no combinational path from any input to any output.

## Test plan
- **Reset:** hold `rst_n` = 1 for 3 cycles with `pulse_en` = 1 and `ext_pulse` = 1 → `count` = 0 and `overflow` = 0 throughout. After release, exactly one external event is counted: `count` = 1 at release+`FILTER_LEN`+2.
- **Software wrap:** 8 single-cycle `pulse_en` strobes → `count` steps 1..7 then 0. `overflow` = 1 only in the cycle `count` first reads 0.
- **Glitch filter:** with `FILTER_LEN` = 4, a 3-cycle `ext_pulse` high → no count change. A 10-cycle high → `count` +1 exactly 5 cycles after the first high sample. A second 10-cycle high after a 10-cycle low → another +1.
- **Simultaneous events:** preload `count` = 6, then align a `pulse_en` strobe with `ext_evt` → `count` = 0 and `overflow` = 1. Repeat from 7 → `count` = 1 and `overflow` = 1.
- **Clear priority:** `count` = 5, assert `count_clr` for 4 cycles with `pulse_en` strobes every cycle → `count` = 0 from the next cycle and `overflow` never 1. Deassert `count_clr` with one `pulse_en` → `count` = 1.
- **Reset mid-qualification:** assert `rst_n` while the FSM is in `RISE_Q` with `qcnt` = 2 and `ext_pulse` held high → no event at the original due cycle. After release, exactly one event follows at the full requalification latency.
